// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a registered carry,
// start/busy/done handshake, results held until the next completion.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N < 2) ? 1 : $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   slice;
    logic             accept;
    logic             last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start during RUN is simply not looked at
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy   = (state == RUN);
        accept = (state == IDLE) && start;
        last   = (state == RUN) && (cnt == LAST);
    end

    assign slice = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

    // Result shift register only needs the bits below the incoming slice
    if (N == 1) begin : g_single
        assign res_next = slice[DIGIT-1:0];
    end else begin : g_multi
        logic [WIDTH-DIGIT-1:0] res_sr;

        assign res_next = {slice[DIGIT-1:0], res_sr};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_sr <= '0;
            end else if (busy) begin
                res_sr <= res_next[WIDTH-1:DIGIT];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                // Subtraction is a + ~b + !borrow_in
                a_sr  <= a;
                b_sr  <= sub ? ~b : b;
                carry <= c_in ^ sub;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1] ^ sub;
                cnt   <= '0;
            end else if (busy) begin
                a_sr  <= a_sr >> DIGIT;
                b_sr  <= b_sr >> DIGIT;
                carry <= slice[DIGIT];
                cnt   <= cnt + CW'(1);
                if (last) begin
                    sum      <= res_next;
                    c_out    <= slice[DIGIT];
                    overflow <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
                end
            end
        end
    end

endmodule
